rf_wb_arbiter: RTL and testbench
================================

# rf_wb_arbiter

Write-back arbiter and scoreboard for the 32×32 register file `rf`, which has one synchronous write port and two combinational read ports. The block shares the single write port between two write-back requesters: A (ALU) and B (load unit). It tracks which destination registers have writes still outstanding. It stalls decode issue on read-after-write and write-after-write hazards. It sits between decode/execute and `rf`, and is the only block that drives the `rf` write port.

## Interface
- `NUM_REGS`, 32, number of architectural registers; x0 is hardwired zero.
- `ADDR_W`, 5, register address width.
- `DATA_W`, 32, write data width.

- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `issue_valid`  in  1  decode presents an instruction this cycle.
- `issue_rs1`, `issue_rs2`  in  ADDR_W  source registers to check.
- `issue_rd`  in  ADDR_W  destination register to mark pending.
- `issue_stall`  out  1  issue refused this cycle (combinational).
- `a_valid`, `b_valid`  in  1  requester has a write-back pending.
- `a_rd`, `b_rd`  in  ADDR_W  write-back destination.
- `a_data`, `b_data`  in  DATA_W  write-back value.
- `a_ready`, `b_ready`  out  1  grant; a transfer occurs when valid and ready are both high at a clock edge.
- `rf_rd`  out  ADDR_W  drives `rf.rd`.
- `rf_write_e`  out  1  drives `rf.write_e`.
- `rf_write_d`  out  DATA_W  drives `rf.write_d`.
- `wb_orphan`  out  1  one-cycle pulse: the accepted write-back targeted a register that was not busy.
- `idle`  out  1  no busy bits are set and the write stage is empty.

## Operation
- **State**
  - `busy[NUM_REGS-1:1]` scoreboard; bit 0 does not exist and always reads 0.
  - Write stage register `{ws_valid, ws_rd, ws_data}`.
  - Round-robin pointer `last_b` (1 = B was granted most recently).
- **Issue**
  - `issue_stall = issue_valid & (busy[issue_rs1] | busy[issue_rs2] | busy[issue_rd])`.
  - Accepted issue means `issue_valid & ~issue_stall`. At that edge, `busy[issue_rd]` is set, unless `issue_rd == 0`.
- **Arbitration** (combinational)
  - Only one valid: that requester is granted.
  - Both valid: grant A if `last_b == 1`, otherwise grant B.
  - Neither valid: no grant.
  - At most one ready is high per cycle. The ready of a non-valid requester is 0.
  - `last_b` updates on every transfer: set to 1 for B, 0 for A.
- **Write stage**
  - On a transfer edge: `ws_valid <= (rd != 0)`, `ws_rd <= rd`, `ws_data <= data`. With no transfer, `ws_valid <= 0`.
  - `rf_write_e = ws_valid`, `rf_rd = ws_rd`, `rf_write_d = ws_data`.
  - `rf` commits the write on the edge after the transfer. `busy[ws_rd]` clears on that same edge.
- **Set/clear on the same edge**
  - A set on the same register as a pending clear cannot occur, because the WAW term stalls it.
  - The rule is still fixed: if set and clear hit the same bit on the same edge, the set wins.
- **Orphan write-backs**
  - A transfer whose rd is nonzero and not busy at the transfer edge raises `wb_orphan` for the next cycle.
  - The write is still performed.
- **rd = 0 write-backs:** the handshake completes, the data is dropped, `rf_write_e` stays 0, and `wb_orphan` stays 0.
- **`idle`** = `~|busy & ~ws_valid`.

## Timing
- **Reset** (asynchronous, takes effect immediately and mid-operation):
  - `busy` = 0, `ws_valid` = 0, `ws_rd` = 0, `ws_data` = 0, `last_b` = 1 (A wins the first tie), `wb_orphan` = 0.
  - Outputs during reset: `rf_write_e` = 0, `idle` = 1.
  - `issue_stall`, `a_ready` and `b_ready` still follow their combinational equations, with `busy` = 0.
  - A write in flight is lost.
- **Latency:** transfer at edge N → `rf_write_e` high in cycle N..N+1 → `rf` updated and busy bit cleared at edge N+1.
- **Earliest dependent issue:**
  - A dependent instruction is unstalled in cycle N+1..N+2.
  - A read it issues then sees the new value, because `rf` reads are combinational.
- **Throughput:** one write per cycle. Back-to-back transfers on consecutive edges are supported.
- **Stall path:** combinational from `issue_*` and `busy` only; no dependence on `a_*`/`b_*`.

## Test plan
- Reset, issue rd=4 then A writes 42 to x4 → `issue_stall` high for `rs1=4` until edge N+1; `rf` x4 = 42; busy[4] clear; `idle` = 1.
- A and B both valid continuously (x2 = 99, x5 = 7, repeated) → grants alternate A, B, A, B; first grant goes to A; `rf_write_e` high every cycle.
- B writes rd=0 with data 0xDEADBEEF → `b_ready` = 1, `rf_write_e` stays 0, x0 reads 0, `wb_orphan` = 0.
- A writes x9 = 5 with busy[9] clear → `wb_orphan` pulses for one cycle; x9 = 5.
- Issue rd=3 while busy[3] is set → `issue_stall` = 1 and busy is unchanged. After the write-back to x3, the same issue is accepted and busy[3] is set again.
- Assert `rst_n` low mid-cycle with `ws_valid` = 1 and busy[7] set → `rf_write_e` drops immediately, x7 is unchanged, and `idle` = 1 after release.

Source files
------------

// File: rtl/rf_wb_arbiter_if.sv
// Handshake and register-file bus bundle for the write-back arbiter.
// master: decode/execute side plus the rf it drives; slave: the arbiter.
interface rf_wb_arbiter_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
);
  logic              issue_valid;
  logic [ADDR_W-1:0] issue_rs1;
  logic [ADDR_W-1:0] issue_rs2;
  logic [ADDR_W-1:0] issue_rd;
  logic              issue_stall;

  logic              a_valid;
  logic [ADDR_W-1:0] a_rd;
  logic [DATA_W-1:0] a_data;
  logic              a_ready;

  logic              b_valid;
  logic [ADDR_W-1:0] b_rd;
  logic [DATA_W-1:0] b_data;
  logic              b_ready;

  logic [ADDR_W-1:0] rf_rd;
  logic              rf_write_e;
  logic [DATA_W-1:0] rf_write_d;

  logic              wb_orphan;
  logic              idle;

  modport master (
    output issue_valid, issue_rs1, issue_rs2, issue_rd,
    input  issue_stall,
    output a_valid, a_rd, a_data,
    input  a_ready,
    output b_valid, b_rd, b_data,
    input  b_ready,
    input  rf_rd, rf_write_e, rf_write_d, wb_orphan, idle
  );

  modport slave (
    input  issue_valid, issue_rs1, issue_rs2, issue_rd,
    output issue_stall,
    input  a_valid, a_rd, a_data,
    output a_ready,
    input  b_valid, b_rd, b_data,
    output b_ready,
    output rf_rd, rf_write_e, rf_write_d, wb_orphan, idle
  );
endinterface

// File: rtl/rf_wb_arbiter.sv
// Write-back arbiter + busy scoreboard in front of the 32x32 register file.
// Shares the single rf write port between the ALU (A) and load unit (B),
// round-robin on ties, and stalls issue on RAW/WAW hazards.
module rf_wb_arbiter #(
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = 5,
  parameter int DATA_W   = 32
) (
  input  logic           clk,
  input  logic           rst_n,
  rf_wb_arbiter_if.slave bus
);

  logic [NUM_REGS-1:1] busy_q;
  logic [NUM_REGS-1:0] busy_full;   // x0 slot tied low for direct indexing
  logic [NUM_REGS-1:1] set_vec;
  logic [NUM_REGS-1:1] clr_vec;
  logic [NUM_REGS-1:1] busy_nxt;

  logic              ws_valid;
  logic [ADDR_W-1:0] ws_rd;
  logic [DATA_W-1:0] ws_data;
  logic              last_b;
  logic              wb_orphan_q;

  logic              issue_acc;
  logic              a_gnt, b_gnt, xfer;
  logic [ADDR_W-1:0] sel_rd;
  logic [DATA_W-1:0] sel_data;
  logic              orphan_d;

  assign busy_full = {busy_q, 1'b0};

  // Hazard check depends only on issue fields and the scoreboard
  assign bus.issue_stall = bus.issue_valid &
                           (busy_full[bus.issue_rs1] | busy_full[bus.issue_rs2] |
                            busy_full[bus.issue_rd]);
  assign issue_acc = bus.issue_valid & ~bus.issue_stall;

  // Round-robin: on a tie, the requester not granted last time wins
  assign a_gnt    = bus.a_valid & (~bus.b_valid | last_b);
  assign b_gnt    = bus.b_valid & (~bus.a_valid | ~last_b);
  assign xfer     = a_gnt | b_gnt;
  assign sel_rd   = a_gnt ? bus.a_rd   : bus.b_rd;
  assign sel_data = a_gnt ? bus.a_data : bus.b_data;
  assign bus.a_ready = a_gnt;
  assign bus.b_ready = b_gnt;

  // Orphan: nonzero destination that nobody marked busy
  assign orphan_d = xfer & (sel_rd != '0) & ~busy_full[sel_rd];

  // Per-register set (accepted issue) and clear (write stage commit) decode
  for (genvar r = 1; r < NUM_REGS; r++) begin : g_sb
    assign set_vec[r] = issue_acc & (bus.issue_rd == ADDR_W'(r));
    assign clr_vec[r] = ws_valid  & (ws_rd        == ADDR_W'(r));
  end

  // Set wins over clear when both hit the same bit
  assign busy_nxt = (busy_q & ~clr_vec) | set_vec;

  // Scoreboard, write stage, arbitration pointer and orphan pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q      <= '0;
      ws_valid    <= 1'b0;
      ws_rd       <= '0;
      ws_data     <= '0;
      last_b      <= 1'b1;
      wb_orphan_q <= 1'b0;
    end else begin
      busy_q      <= busy_nxt;
      wb_orphan_q <= orphan_d;
      if (xfer) begin
        ws_valid <= (sel_rd != '0);
        ws_rd    <= sel_rd;
        ws_data  <= sel_data;
        last_b   <= b_gnt;
      end else begin
        ws_valid <= 1'b0;
      end
    end
  end

  assign bus.rf_write_e = ws_valid;
  assign bus.rf_rd      = ws_rd;
  assign bus.rf_write_d = ws_data;
  assign bus.wb_orphan  = wb_orphan_q;
  assign bus.idle       = ~|busy_q & ~ws_valid;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed bench for rf_wb_arbiter: a combinational vector table plus
// hand-written multi-cycle sequences, with a small rf model behind the port.
module tb_rf_wb_arbiter;

  logic clk;
  logic rst_n;

  rf_wb_arbiter_if #(.ADDR_W(5), .DATA_W(32)) bus ();

  rf_wb_arbiter #(.NUM_REGS(32), .ADDR_W(5), .DATA_W(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file model fed by the write port
  logic [31:0] rf_mem [32] = '{default: '0};
  always @(posedge clk)
    if (bus.rf_write_e) rf_mem[bus.rf_rd] <= bus.rf_write_d;

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic clr_in();
    bus.issue_valid = 0; bus.issue_rs1 = 0; bus.issue_rs2 = 0; bus.issue_rd = 0;
    bus.a_valid = 0; bus.a_rd = 0; bus.a_data = 0;
    bus.b_valid = 0; bus.b_rd = 0; bus.b_data = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    string      nm;
    logic       iv;
    logic [4:0] rs1, rs2, rd;
    logic       av, bv;
    logic       stall, ar, br;
  } vec_t;

  vec_t vecs[10];

  initial begin
    // Table assumes busy = {x6}, last_b = 1
    vecs[0] = '{"raw_rs1",   1, 6, 0, 0, 1, 0, 1, 1, 0};
    vecs[1] = '{"raw_rs2",   1, 1, 6, 0, 0, 0, 1, 0, 0};
    vecs[2] = '{"waw_rd",    1, 0, 0, 6, 0, 1, 1, 0, 1};
    vecs[3] = '{"no_issue",  0, 6, 6, 6, 0, 0, 0, 0, 0};
    vecs[4] = '{"clean",     1, 1, 2, 3, 0, 0, 0, 0, 0};
    vecs[5] = '{"all_x0",    1, 0, 0, 0, 0, 0, 0, 0, 0};
    vecs[6] = '{"a_only",    0, 0, 0, 0, 1, 0, 0, 1, 0};
    vecs[7] = '{"b_only",    0, 0, 0, 0, 0, 1, 0, 0, 1};
    vecs[8] = '{"tie_a",     1, 7, 0, 0, 1, 1, 0, 1, 0};
    vecs[9] = '{"none",      1, 0, 6, 0, 0, 0, 1, 0, 0};

    clr_in();
    rst_n = 0;
    #1;
    chk("rst_write_e", {31'd0, bus.rf_write_e}, 0);
    chk("rst_idle",    {31'd0, bus.idle}, 1);
    chk("rst_orphan",  {31'd0, bus.wb_orphan}, 0);
    bus.issue_valid = 1; bus.issue_rs1 = 4; bus.a_valid = 1;
    #1;
    chk("rst_stall",   {31'd0, bus.issue_stall}, 0);
    chk("rst_a_ready", {31'd0, bus.a_ready}, 1);
    clr_in();
    #11 rst_n = 1;

    // Mark x6 busy
    step();
    bus.issue_valid = 1; bus.issue_rd = 6;
    step();
    clr_in();

    for (int i = 0; i < 10; i++) begin
      step();
      bus.issue_valid = vecs[i].iv; bus.issue_rs1 = vecs[i].rs1;
      bus.issue_rs2 = vecs[i].rs2;  bus.issue_rd  = vecs[i].rd;
      bus.a_valid = vecs[i].av; bus.a_rd = 1;
      bus.b_valid = vecs[i].bv; bus.b_rd = 2;
      #1;
      chk({vecs[i].nm, "_stall"}, {31'd0, bus.issue_stall}, {31'd0, vecs[i].stall});
      chk({vecs[i].nm, "_a_rdy"}, {31'd0, bus.a_ready},     {31'd0, vecs[i].ar});
      chk({vecs[i].nm, "_b_rdy"}, {31'd0, bus.b_ready},     {31'd0, vecs[i].br});
      clr_in();
    end

    // Retire x6
    step();
    bus.a_valid = 1; bus.a_rd = 6; bus.a_data = 1;
    step();
    clr_in();
    step();

    // Issue rd=4, then A writes 42 to x4
    bus.issue_valid = 1; bus.issue_rd = 4;
    step();
    clr_in();
    bus.issue_valid = 1; bus.issue_rs1 = 4;
    #1;
    chk("x4_stall_pre", {31'd0, bus.issue_stall}, 1);
    chk("x4_idle_pre",  {31'd0, bus.idle}, 0);
    bus.a_valid = 1; bus.a_rd = 4; bus.a_data = 42;
    #1;
    chk("x4_a_ready", {31'd0, bus.a_ready}, 1);
    step();
    chk("x4_write_e", {31'd0, bus.rf_write_e}, 1);
    chk("x4_rf_rd",   {27'd0, bus.rf_rd}, 4);
    chk("x4_rf_d",    bus.rf_write_d, 42);
    chk("x4_stall_n", {31'd0, bus.issue_stall}, 1);
    chk("x4_orphan",  {31'd0, bus.wb_orphan}, 0);
    bus.a_valid = 0;
    step();
    chk("x4_stall_n1", {31'd0, bus.issue_stall}, 0);
    chk("x4_rf_val",   rf_mem[4], 42);
    chk("x4_idle",     {31'd0, bus.idle}, 1);
    chk("x4_we_off",   {31'd0, bus.rf_write_e}, 0);
    clr_in();

    // Fresh reset, then both requesters valid continuously
    rst_n = 0;
    #2 rst_n = 1;
    bus.a_valid = 1; bus.a_rd = 2; bus.a_data = 99;
    bus.b_valid = 1; bus.b_rd = 5; bus.b_data = 7;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("rr%0d_a_rdy", i), {31'd0, bus.a_ready}, (i % 2 == 0) ? 1 : 0);
      chk($sformatf("rr%0d_b_rdy", i), {31'd0, bus.b_ready}, (i % 2 == 0) ? 0 : 1);
      step();
      chk($sformatf("rr%0d_we", i), {31'd0, bus.rf_write_e}, 1);
      chk($sformatf("rr%0d_rd", i), {27'd0, bus.rf_rd}, (i % 2 == 0) ? 2 : 5);
    end
    clr_in();
    step();
    chk("rr_x2", rf_mem[2], 99);
    chk("rr_x5", rf_mem[5], 7);

    // B writes x0: handshake only
    bus.b_valid = 1; bus.b_rd = 0; bus.b_data = 32'hDEADBEEF;
    #1;
    chk("x0_b_ready", {31'd0, bus.b_ready}, 1);
    step();
    chk("x0_we",     {31'd0, bus.rf_write_e}, 0);
    chk("x0_orphan", {31'd0, bus.wb_orphan}, 0);
    clr_in();
    step();
    chk("x0_val", rf_mem[0], 0);

    // Orphan write to x9
    bus.a_valid = 1; bus.a_rd = 9; bus.a_data = 5;
    step();
    chk("x9_orphan", {31'd0, bus.wb_orphan}, 1);
    chk("x9_we",     {31'd0, bus.rf_write_e}, 1);
    clr_in();
    step();
    chk("x9_orphan_off", {31'd0, bus.wb_orphan}, 0);
    chk("x9_val", rf_mem[9], 5);

    // WAW stall on x3, then re-issue after write-back
    bus.issue_valid = 1; bus.issue_rd = 3;
    step();
    #1;
    chk("x3_stall", {31'd0, bus.issue_stall}, 1);
    step();
    chk("x3_stall_hold", {31'd0, bus.issue_stall}, 1);
    bus.a_valid = 1; bus.a_rd = 3; bus.a_data = 11;
    step();
    bus.a_valid = 0;
    #1;
    chk("x3_stall_wsN",  {31'd0, bus.issue_stall}, 1);
    chk("x3_orphan",     {31'd0, bus.wb_orphan}, 0);
    step();
    chk("x3_unstall", {31'd0, bus.issue_stall}, 0);
    chk("x3_val",     rf_mem[3], 11);
    step();
    chk("x3_reissue", {31'd0, bus.issue_stall}, 1);
    clr_in();
    #1;
    chk("x3_idle", {31'd0, bus.idle}, 0);

    // Reset mid-cycle with x7 write in flight
    step();
    bus.issue_valid = 1; bus.issue_rd = 7;
    step();
    clr_in();
    bus.a_valid = 1; bus.a_rd = 7; bus.a_data = 32'h77;
    step();
    chk("x7_we", {31'd0, bus.rf_write_e}, 1);
    bus.a_valid = 0;
    #1 rst_n = 0;
    #1;
    chk("x7_rst_we",   {31'd0, bus.rf_write_e}, 0);
    chk("x7_rst_idle", {31'd0, bus.idle}, 1);
    @(posedge clk);
    #2 rst_n = 1;
    step();
    chk("x7_val",   rf_mem[7], 0);
    chk("x7_idle",  {31'd0, bus.idle}, 1);
    bus.issue_valid = 1; bus.issue_rs1 = 7; bus.issue_rs2 = 3;
    #1;
    chk("x7_stall", {31'd0, bus.issue_stall}, 0);
    clr_in();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
